// File: rtl/vote_pkg.sv
// Shared types and constants for the three-voter ballot round controller.
package vote_pkg;

  localparam int NUM_VOTERS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2
  } state_t;

endpackage

// File: rtl/vote_round_ctrl_majority3.sv
// Combinational 2-of-3 majority used to decide the round outcome.
module majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/vote_round_ctrl.sv
// One voting round: timed ballot window, per-voter valid/ack capture, majority tally.
module vote_round_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000000,
  parameter int TW            = $clog2(WINDOW_CYCLES)
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       start,
  input  logic [2:0] vote_valid,
  input  logic [2:0] vote_val,
  output logic [2:0] vote_ack,
  output logic       busy,
  output logic       result,
  output logic       result_valid,
  output logic       timed_out,
  output logic [2:0] missing,
  output logic [7:0] round_cnt
);

  state_t                state_q;
  state_t                state_d;
  logic [TW-1:0]         timer_q;
  logic [NUM_VOTERS-1:0] cast_q;
  logic [NUM_VOTERS-1:0] ballot_q;
  logic [NUM_VOTERS-1:0] accept;
  logic                  maj_y;

  majority3 u_majority3 (
    .a (ballot_q[0]),
    .b (ballot_q[1]),
    .c (ballot_q[2]),
    .y (maj_y)
  );

  // Exit includes votes accepted this cycle, so a final vote on timer==0 still counts.
  always_comb begin
    state_d = state_q;
    accept  = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = OPEN;
      end
      OPEN: begin
        accept = vote_valid & ~cast_q;
        if ((&(cast_q | accept)) || (timer_q == '0)) state_d = TALLY;
      end
      TALLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cast_q       <= '0;
      ballot_q     <= '0;
      vote_ack     <= '0;
      busy         <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
      missing      <= '0;
      round_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      vote_ack     <= accept;
      busy         <= (state_d == OPEN) || (state_d == TALLY);
      result_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cast_q   <= '0;
            ballot_q <= '0;
            timer_q  <= TW'(WINDOW_CYCLES - 1);
          end
        end
        OPEN: begin
          cast_q   <= cast_q | accept;
          ballot_q <= (ballot_q & ~accept) | (vote_val & accept);
          if (timer_q != '0) timer_q <= timer_q - TW'(1);
        end
        TALLY: begin
          result       <= maj_y;
          result_valid <= 1'b1;
          missing      <= ~cast_q;
          timed_out    <= |(~cast_q);
          round_cnt    <= round_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Directed bench for vote_round_ctrl with a result scoreboard.
module tb_vote_round_ctrl;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       start;
  logic [2:0] vote_valid;
  logic [2:0] vote_val;
  logic [2:0] vote_ack;
  logic       busy;
  logic       result;
  logic       result_valid;
  logic       timed_out;
  logic [2:0] missing;
  logic [7:0] round_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic       result;
    logic       timed_out;
    logic [2:0] missing;
    logic [7:0] round_cnt;
  } exp_t;

  exp_t sb[$];

  vote_round_ctrl #(.WINDOW_CYCLES(16)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_val     (vote_val),
    .vote_ack     (vote_ack),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .timed_out    (timed_out),
    .missing      (missing),
    .round_cnt    (round_cnt)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: effective ballot is vote value of cast voters only; majority by popcount.
  task automatic push_exp(input logic [2:0] vals, input logic [2:0] cast, input logic [7:0] rc);
    exp_t e;
    logic [2:0] eff;
    eff         = vals & cast;
    e.result    = ($countones(eff) >= 2);
    e.missing   = ~cast;
    e.timed_out = (cast != 3'b111);
    e.round_cnt = rc;
    sb.push_back(e);
  endtask

  function automatic logic [17:0] all_outs();
    return {vote_ack, busy, result, result_valid, timed_out, missing, round_cnt};
  endfunction

  always @(negedge CLOCK_50) begin
    if (RESET_N && result_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result_fields", 32'({result, timed_out, missing, round_cnt}), 32'(e));
      end
    end
  end

  initial begin
    logic [2:0] rv;
    RESET_N    = 1'b0;
    start      = 1'b0;
    vote_valid = 3'b000;
    vote_val   = 3'b000;

    // Reset hold and release
    ticks(3);
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    RESET_N = 1'b1;
    vote_valid = 3'b111;
    vote_val   = 3'b111;
    ticks(2);
    chk("idle_outputs_zero_votes_ignored", 32'(all_outs()), 32'd0);
    vote_valid = 3'b000;
    vote_val   = 3'b000;

    // All three vote in one cycle
    do_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    vote_valid = 3'b111;
    vote_val   = 3'b110;
    push_exp(3'b110, 3'b111, 8'd1);
    tick();
    vote_valid = 3'b000;
    chk("ack_all_same_cycle", 32'(vote_ack), 32'b111);
    chk("busy_in_tally", 32'(busy), 32'd1);
    tick();
    chk("result_valid_t_plus_2", 32'(result_valid), 32'd1);
    chk("ack_one_cycle", 32'(vote_ack), 32'd0);
    chk("busy_low_after_tally", 32'(busy), 32'd0);
    tick();
    chk("result_valid_single_pulse", 32'(result_valid), 32'd0);
    chk("result_held", 32'(result), 32'd1);

    // Staggered votes with a repeat from voter0
    do_start();
    ticks(2);
    vote_valid = 3'b001; vote_val = 3'b001;
    push_exp(3'b001, 3'b111, 8'd2);
    tick();
    chk("stagger_ack_v0", 32'(vote_ack), 32'b001);
    vote_valid = 3'b000;
    tick();
    vote_valid = 3'b100; vote_val = 3'b000;
    tick();
    chk("stagger_ack_v2", 32'(vote_ack), 32'b100);
    vote_valid = 3'b001; vote_val = 3'b000;
    tick();
    chk("repeat_vote_no_ack", 32'(vote_ack), 32'b000);
    chk("repeat_vote_still_open", 32'(busy), 32'd1);
    vote_valid = 3'b000;
    tick();
    vote_valid = 3'b010; vote_val = 3'b000;
    tick();
    chk("stagger_ack_v1", 32'(vote_ack), 32'b010);
    vote_valid = 3'b000;
    ticks(2);

    // Window expiry with only voter1 voting yes
    do_start();
    vote_valid = 3'b010; vote_val = 3'b010;
    push_exp(3'b010, 3'b010, 8'd3);
    tick();
    chk("timeout_ack_v1", 32'(vote_ack), 32'b010);
    vote_valid = 3'b000;
    ticks(14);
    chk("timeout_still_busy", 32'(busy), 32'd1);
    chk("timeout_no_early_result", 32'(result_valid), 32'd0);
    tick();
    chk("timeout_tally_no_result_yet", 32'(result_valid), 32'd0);
    tick();
    chk("timeout_result_valid", 32'(result_valid), 32'd1);
    chk("timeout_missing", 32'(missing), 32'b101);
    chk("timeout_flag", 32'(timed_out), 32'd1);
    tick();

    // Final vote coincides with timer==0
    do_start();
    vote_valid = 3'b101; vote_val = 3'b001;
    tick();
    chk("lastcycle_first_acks", 32'(vote_ack), 32'b101);
    vote_valid = 3'b000;
    ticks(14);
    chk("lastcycle_still_open", 32'(busy), 32'd1);
    vote_valid = 3'b010; vote_val = 3'b010;
    push_exp(3'b011, 3'b111, 8'd4);
    tick();
    vote_valid = 3'b000;
    chk("lastcycle_vote_acked", 32'(vote_ack), 32'b010);
    tick();
    chk("lastcycle_not_timed_out", 32'({result_valid, timed_out}), 32'b10);
    tick();

    // Reset mid-round abandons it
    do_start();
    vote_valid = 3'b011; vote_val = 3'b011;
    tick();
    chk("midreset_acks", 32'(vote_ack), 32'b011);
    vote_valid = 3'b000;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midreset_outputs_zero", 32'(all_outs()), 32'd0);
    ticks(2);
    RESET_N = 1'b1;
    ticks(20);
    chk("midreset_no_tally", 32'({result_valid, busy, round_cnt}), 32'd0);

    // 256 back-to-back rounds, round_cnt wraps
    for (int r = 1; r <= 256; r++) begin
      do_start();
      rv = 3'($urandom_range(0, 7));
      vote_valid = 3'b111;
      vote_val   = rv;
      push_exp(rv, 3'b111, 8'(r));
      tick();
      vote_valid = 3'b000;
      tick();
    end
    ticks(3);
    chk("round_cnt_wrapped", 32'(round_cnt), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
